// File: rtl/alu_pkg.sv
// alu_pkg: op-code constants, FSM state encoding and shift kinds shared by the ALU unit.
package alu_pkg;
    localparam logic [3:0] ALU_OP_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_OP_INC_A  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD    = 4'b0010;
    localparam logic [3:0] ALU_OP_ADD_C  = 4'b0011;
    localparam logic [3:0] ALU_OP_SUBB   = 4'b0100;
    localparam logic [3:0] ALU_OP_SUB    = 4'b0101;
    localparam logic [3:0] ALU_OP_DEC_A  = 4'b0110;
    localparam logic [3:0] ALU_OP_PASS_C = 4'b0111;
    localparam logic [3:0] ALU_OP_OR     = 4'b1000;
    localparam logic [3:0] ALU_OP_XNOR   = 4'b1010;
    localparam logic [3:0] ALU_OP_XOR    = 4'b1100;
    localparam logic [3:0] ALU_OP_NOT    = 4'b1110;
    localparam logic [3:0] ALU_OP_SHL    = 4'b1001;
    localparam logic [3:0] ALU_OP_SHR    = 4'b1011;
    localparam logic [3:0] ALU_OP_SRA    = 4'b1101;
    localparam logic [3:0] ALU_OP_ROL    = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
    typedef enum logic [1:0] {SH_SHL, SH_SHR, SH_SRA, SH_ROL} shift_t;
endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: combinational adder/logic/one-step shifter with Z/N/C/V flags.
// ALU_SHIFT_EN: logic ops with cin=1 become shifts (zero-amount form passes A through here).
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_sh_val,
    input  logic [1:0]       i_sh_kind,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf
);
    logic [WIDTH-1:0] w_y, w_logic, w_step;
    logic [WIDTH:0]   w_sum;
    logic             w_step_bit, w_shift_op;

`ifdef ALU_SHIFT_EN
    assign w_shift_op = i_op[3] & i_op[0];
`else
    assign w_shift_op = 1'b0;
`endif

    always_comb begin
        w_y = i_op[2:1] == 2'b00 ? '0 : i_op[2:1] == 2'b01 ? i_b : i_op[2:1] == 2'b10 ? ~i_b : '1;
        w_sum = {1'b0, i_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, i_op[0]};
        w_logic = i_op[2:1] == 2'b00 ? i_a | i_b : i_op[2:1] == 2'b01 ? ~(i_a ^ i_b) :
                  i_op[2:1] == 2'b10 ? i_a ^ i_b : ~i_a;
        w_step = i_sh_kind == SH_SHL ? {i_sh_val[WIDTH-2:0], 1'b0} :
                 i_sh_kind == SH_SHR ? {1'b0, i_sh_val[WIDTH-1:1]} :
                 i_sh_kind == SH_SRA ? {i_sh_val[WIDTH-1], i_sh_val[WIDTH-1:1]} :
                                       {i_sh_val[WIDTH-2:0], i_sh_val[WIDTH-1]};
        // left shifts lose the msb, right shifts lose the lsb
        w_step_bit = (i_sh_kind == SH_SHL || i_sh_kind == SH_ROL) ? i_sh_val[WIDTH-1] : i_sh_val[0];
        o_res  = i_step ? w_step : w_shift_op ? i_a : i_op[3] ? w_logic : w_sum[WIDTH-1:0];
        o_cout = i_step ? w_step_bit : i_op[3] ? 1'b0 : w_sum[WIDTH];
        o_ovf  = (i_step || i_op[3]) ? 1'b0 :
                 (i_a[WIDTH-1] == w_y[WIDTH-1]) & (w_sum[WIDTH-1] != i_a[WIDTH-1]);
        o_zero = o_res == '0;
        o_neg  = o_res[WIDTH-1];
    end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with valid/ready on both sides and an IDLE/BUSY/DONE FSM.
// ALU_SHIFT_EN enables multi-cycle shifts; without it BUSY is never entered.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int SW = $clog2(WIDTH);

    state_t           r_state, w_next;
    shift_t           r_kind;
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh, r_result, w_res;
    logic             r_cout, r_zero, r_neg, r_ovf;
    logic             w_cout, w_zero, w_neg, w_ovf;
    logic             w_accept, w_is_shift, w_start_busy, w_busy, w_last;

`ifdef ALU_SHIFT_EN
    assign w_is_shift = op[3] & op[0];
`else
    assign w_is_shift = 1'b0;
`endif

    assign w_start_busy = w_is_shift & (b[SW-1:0] != '0);
    assign w_busy = r_state == ST_BUSY;
    assign w_last = w_busy & (r_cnt == SW'(1));

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .i_op      (op),
        .i_a       (a),
        .i_b       (b),
        .i_step    (w_busy),
        .i_sh_val  (r_sh),
        .i_sh_kind (r_kind),
        .o_res     (w_res),
        .o_cout    (w_cout),
        .o_zero    (w_zero),
        .o_neg     (w_neg),
        .o_ovf     (w_ovf)
    );

    always_comb begin
        in_ready  = r_state == ST_IDLE || (r_state == ST_DONE && out_ready);
        out_valid = r_state == ST_DONE;
        w_accept  = in_valid & in_ready;
        w_next    = r_state;
        if (w_accept)
            w_next = w_start_busy ? ST_BUSY : ST_DONE;
        else if (w_last)
            w_next = ST_DONE;
        else if (r_state == ST_DONE && out_ready)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_kind   <= SH_SHL;
        end else begin
            if (w_busy) begin
                r_sh  <= w_res;
                r_cnt <= r_cnt - SW'(1);
            end
            if (w_accept && w_start_busy) begin
                r_sh   <= a;
                r_cnt  <= b[SW-1:0];
                r_kind <= shift_t'(op[2:1]);
            end
            // output registers change only when a result completes, so DONE holds them under backpressure
            if ((w_accept && !w_start_busy) || w_last) begin
                r_result <= w_res;
                r_cout   <= w_cout;
                r_zero   <= w_zero;
                r_neg    <= w_neg;
                r_ovf    <= w_ovf;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign neg    = r_neg;
    assign ovf    = r_ovf;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed tests of alu_seq_unit at WIDTH=8, shift table chosen by ALU_SHIFT_EN.
module tb_alu_seq_unit;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic       cout, zero, neg, ovf;
    logic [3:0] op;
    logic [7:0] a, b, result;
    logic [12:0] obs;
    int checks = 0;
    int fails = 0;

    // {op, a, b, expected {out_valid, result, cout, zero, neg, ovf}}
    logic [32:0] b2b_tab [9] = '{
        {ALU_OP_DEC_A,  8'h10, 8'h00, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0},
        {ALU_OP_OR,     8'hF0, 8'h0F, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_XOR,    8'hAA, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
        {ALU_OP_NOT,    8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_XNOR,   8'h0F, 8'h05, 1'b1, 8'hF5, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_ADD,    8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1},
        {ALU_OP_SUB,    8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_SUBB,   8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0},
        {ALU_OP_PASS_C, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}
    };

    // {op, a, b, edges from accept to out_valid, expected flags/result}
`ifdef ALU_SHIFT_EN
    logic [36:0] sh_tab [5] = '{
        {ALU_OP_SHL, 8'h81, 8'h03, 4'd4, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0},
        {ALU_OP_SRA, 8'h90, 8'h02, 4'd3, 1'b1, 8'hE4, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_SHR, 8'h5A, 8'h08, 4'd1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0},
        {ALU_OP_ROL, 8'h81, 8'h01, 4'd2, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0},
        {ALU_OP_SHR, 8'h81, 8'h01, 4'd2, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0}
    };
`else
    logic [36:0] sh_tab [5] = '{
        {ALU_OP_SHL, 8'h81, 8'h03, 4'd1, 1'b1, 8'h83, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_SHR, 8'h81, 8'h03, 4'd1, 1'b1, 8'h7D, 1'b0, 1'b0, 1'b0, 1'b0},
        {ALU_OP_SRA, 8'h90, 8'h02, 4'd1, 1'b1, 8'h92, 1'b0, 1'b0, 1'b1, 1'b0},
        {ALU_OP_ROL, 8'h81, 8'h01, 4'd1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0},
        {ALU_OP_SHR, 8'h5A, 8'h08, 4'd1, 1'b1, 8'hAD, 1'b0, 1'b0, 1'b1, 1'b0}
    };
`endif

    assign obs = {out_valid, result, cout, zero, neg, ovf};

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_arith();
        op = ALU_OP_ADD_C; a = 8'hFF; b = 8'h00; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL add_carry: got %h expected %h", obs, {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL return_idle: got out_valid %b expected 0", out_valid);
        end
        op = ALU_OP_SUB; a = 8'h80; b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL sub_ovf: got %h expected %h", obs, {1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        op = ALU_OP_INC_A; a = 8'h05; b = 8'h00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = ALU_OP_ADD; a = 8'h03; b = 8'h04;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== {1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs, {1'b1, 8'h06, 4'b0000});
            end
            checks++;
            if (in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (obs !== {1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bp_next: got %h expected %h", obs, {1'b1, 8'h07, 4'b0000});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        {op, a, b} = b2b_tab[0][32:13];
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            if (i < 8) {op, a, b} = b2b_tab[i+1][32:13];
            else in_valid = 1'b0;
            checks++;
            if (obs !== b2b_tab[i][12:0] || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d]: got %h ready %b expected %h ready 1", i, obs, in_ready, b2b_tab[i][12:0]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: got out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_shift_ops();
        int n;
        for (int i = 0; i < 5; i++) begin
            {op, a, b} = sh_tab[i][36:17];
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            a = 8'h00; b = 8'h00;
            n = 1;
            checks++;
            if (in_ready !== (sh_tab[i][16:13] == 4'd1)) begin
                fails++;
                $display("FAIL shift_ready[%0d]: got %b expected %b", i, in_ready, sh_tab[i][16:13] == 4'd1);
            end
            while (out_valid !== 1'b1 && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            checks++;
            if (n !== int'(sh_tab[i][16:13])) begin
                fails++;
                $display("FAIL shift_latency[%0d]: got %0d expected %0d", i, n, sh_tab[i][16:13]);
            end
            checks++;
            if (obs !== sh_tab[i][12:0]) begin
                fails++;
                $display("FAIL shift_result[%0d]: got %h expected %h", i, obs, sh_tab[i][12:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
`ifdef ALU_SHIFT_EN
        op = ALU_OP_SHL; a = 8'hFF; b = 8'h07; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (obs !== 13'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_busy: got %h ready %b expected 0000 ready 1", obs, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_busy_dropped: got %0d valid cycles expected 0", seen);
        end
`endif
        out_ready = 1'b0;
        op = ALU_OP_ADD; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (obs !== 13'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_done: got %h ready %b expected 0000 ready 1", obs, in_ready);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 4'h0; a = 8'h00; b = 8'h00;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_shift_ops();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
